// File: rtl/spi_slave_regfile_if.sv
// Pin bundle for spi_slave_regfile: SPI serial pins, frame status and backdoor read port.
interface spi_slave_regfile_if;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic [6:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  modport slave (
    input  sclk, ss_n, mosi, dbg_addr,
    output miso, busy, frame_done, frame_err, dbg_rdata
  );

  modport master (
    output sclk, ss_n, mosi, dbg_addr,
    input  miso, busy, frame_done, frame_err, dbg_rdata
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave terminating 40-bit cmd+data frames into a 32-bit word register array.
// Optional SPI_SLV_PARITY_EN adds an even-parity 41st bit to write frames.
module spi_slave_regfile #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               HCLK,
  input  logic               rst,
  spi_slave_regfile_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SPI_SLV_PARITY_EN
  localparam logic [5:0] WR_LAST = 6'd40;
`else
  localparam logic [5:0] WR_LAST = 6'd39;
`endif
  localparam logic [5:0] RD_LAST = 6'd39;

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_END} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_n_sync_q, mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   sclk_s, ss_n_s, mosi_s, rise, fall;

  state_e                 state_q;
  logic [5:0]             cnt_q;
  logic [7:0]             cmd_q, cmd_d;
  logic [31:0]            data_q, data_d;
  logic [31:0]            rd_word_q, rd_word_d;
  logic [31:0]            out_sh_q;
  logic                   wr_pend_q, done_pend_q, err_pend_q;
  logic                   miso_q, frame_done_q, frame_err_q;
  logic                   parity_ok;
  logic [DEPTH-1:0][31:0] mem_q;

  function automatic logic in_range(input logic [6:0] a);
    return {25'd0, a} < 32'(DEPTH);
  endfunction

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_n_s = ss_n_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_dly_q;
  assign fall   = ~sclk_s & sclk_dly_q;

  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_n_sync_q <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      ss_n_sync_q <= {ss_n_sync_q[SYNC_STAGES-2:0], bus.ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_dly_q  <= sclk_s;
    end
  end

  // cmd_d is the full command as it will stand after the current rise
  always_comb begin
    cmd_d     = {cmd_q[6:0], mosi_s};
    data_d    = {data_q[30:0], mosi_s};
    rd_word_d = 32'd0;
    if (!cmd_d[7] && in_range(cmd_d[6:0])) rd_word_d = mem_q[cmd_d[AW-1:0]];
  end

`ifdef SPI_SLV_PARITY_EN
  logic par_q;
  assign parity_ok = (^data_q) == par_q;
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      rd_word_q   <= '0;
      out_sh_q    <= '0;
      wr_pend_q   <= 1'b0;
      done_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
`ifdef SPI_SLV_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      wr_pend_q   <= 1'b0;
      done_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          out_sh_q <= '0;
          if (!ss_n_s) state_q <= CMD;
        end
        CMD: begin
          if (ss_n_s) begin
            state_q    <= IDLE;
            err_pend_q <= 1'b1;
          end else if (rise) begin
            cmd_q <= cmd_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd7) begin
              state_q   <= DATA;
              rd_word_q <= rd_word_d;
            end
          end
        end
        DATA: begin
          if (ss_n_s) begin
            state_q    <= IDLE;
            err_pend_q <= 1'b1;
          end else if (rise) begin
            cnt_q <= cnt_q + 6'd1;
            if (cmd_q[7]) begin
              if (cnt_q < 6'd40) data_q <= data_d;
`ifdef SPI_SLV_PARITY_EN
              else par_q <= mosi_s;
`endif
              if (cnt_q == WR_LAST) state_q <= WAIT_END;
            end else if (cnt_q == RD_LAST) begin
              state_q <= WAIT_END;
            end
          end else if (fall && !cmd_q[7]) begin
            // first fall after the command loads the word; later falls shift it out
            if (cnt_q == 6'd8) out_sh_q <= rd_word_q;
            else               out_sh_q <= {out_sh_q[30:0], 1'b0};
          end
        end
        WAIT_END: begin
          if (ss_n_s) begin
            state_q <= IDLE;
            if (cmd_q[7]) begin
              wr_pend_q   <= in_range(cmd_q[6:0]) && parity_ok;
              done_pend_q <= in_range(cmd_q[6:0]) && parity_ok;
              err_pend_q  <= !(in_range(cmd_q[6:0]) && parity_ok);
            end else begin
              done_pend_q <= in_range(cmd_q[6:0]);
              err_pend_q  <= !in_range(cmd_q[6:0]);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Commit stage: memory write and status pulses land together
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      mem_q        <= '0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (wr_pend_q) mem_q[cmd_q[AW-1:0]] <= data_q;
      frame_done_q <= done_pend_q;
      frame_err_q  <= err_pend_q;
      miso_q       <= (state_q == DATA && !cmd_q[7]) ? out_sh_q[31] : 1'b0;
    end
  end

  assign bus.miso       = miso_q;
  assign bus.busy       = ~ss_n_s;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.dbg_rdata  = in_range(bus.dbg_addr) ? mem_q[bus.dbg_addr[AW-1:0]] : 32'd0;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed + randomized frame bench for spi_slave_regfile against an array model of the register file.
module tb_spi_slave_regfile;
  localparam int DEPTH = 16;
  localparam int HP    = 6;
`ifdef SPI_SLV_PARITY_EN
  localparam bit PAR     = 1'b1;
  localparam int WR_BITS = 41;
`else
  localparam bit PAR     = 1'b0;
  localparam int WR_BITS = 40;
`endif

  logic HCLK = 1'b0;
  logic rst;
  spi_slave_regfile_if bus();

  spi_slave_regfile #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .HCLK (HCLK),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] model [DEPTH];

  always @(negedge HCLK) begin
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Shifts the first nbits of {cmd,payload} MSB first; mv captures miso just before each rise
  task automatic xfer(input logic [7:0] cmd, input logic [32:0] payload, input int nbits,
                      input bit end_frame, output logic [40:0] mv, output logic busy_mid);
    logic [40:0] sh;
    sh = {cmd, payload};
    mv = '0;
    bus.ss_n = 1'b0;
    cyc(HP);
    busy_mid = bus.busy;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = sh[40-i];
      cyc(HP);
      mv[40-i] = bus.miso;
      bus.sclk = 1'b1;
      cyc(HP);
      bus.sclk = 1'b0;
    end
    if (end_frame) begin
      cyc(HP);
      bus.ss_n = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus.dbg_addr = 7'(a);
      #1;
      chk(tag, 64'(bus.dbg_rdata), 64'(model[a]));
    end
  endtask

  task automatic frame(input bit wr, input logic [6:0] addr, input logic [31:0] data,
                       input bit par_good, input int abort_at);
    int nb, d0, e0;
    logic [40:0] mv;
    logic par, busy_mid;
    bit ok, valid;
    logic [31:0] exp_rd;
    valid  = int'(addr) < DEPTH;
    par    = (^data) ^ ~par_good;
    nb     = wr ? WR_BITS : 40;
    if (abort_at > 0) nb = abort_at;
    exp_rd = valid ? model[addr[3:0]] : 32'd0;
    d0 = done_cnt;
    e0 = err_cnt;
    xfer({wr, addr}, {data, par}, nb, 1'b1, mv, busy_mid);
    cyc(12);
    ok = (abort_at == 0) && valid && (!wr || par_good || !PAR);
    if (ok && wr) model[addr[3:0]] = data;
    chk("busy", 64'(busy_mid), 64'(1));
    chk("busy_idle", 64'(bus.busy), 64'(0));
    chk("done_pulse", 64'(done_cnt - d0), 64'(ok));
    chk("err_pulse", 64'(err_cnt - e0), 64'(!ok));
    chk("miso_cmd", 64'(mv[40:33]), 64'(0));
    if (wr) chk("miso_wr", 64'(mv), 64'(0));
    else if (abort_at == 0) chk("rdata", 64'(mv[32:1]), 64'(exp_rd));
    bus.dbg_addr = addr;
    #1;
    chk("dbg", 64'(bus.dbg_rdata), valid ? 64'(model[addr[3:0]]) : 64'(0));
  endtask

  initial begin
    logic [40:0] mv;
    logic busy_mid;
    int d0, e0;
    logic [31:0] rd;
    bit wr;
    logic [6:0] addr;
    int ab;

    for (int a = 0; a < DEPTH; a++) model[a] = 32'd0;
    rst = 1'b1;
    bus.sclk = 1'b0;
    bus.ss_n = 1'b1;
    bus.mosi = 1'b0;
    bus.dbg_addr = 7'd0;
    cyc(4);
    chk("rst_miso", 64'(bus.miso), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.frame_done), 64'(0));
    chk("rst_err", 64'(bus.frame_err), 64'(0));
    check_all("rst_mem");
    rst = 1'b0;
    cyc(4);

    frame(1'b1, 7'd0, 32'hA5A5A5A5, 1'b1, 0);
    frame(1'b1, 7'd1, 32'h5A5A5A5A, 1'b1, 0);
    frame(1'b0, 7'd1, 32'd0, 1'b1, 0);
    frame(1'b0, 7'd0, 32'd0, 1'b1, 0);
    frame(1'b1, 7'd16, 32'hDEADBEEF, 1'b1, 0);
    check_all("oob_wr_mem");
    frame(1'b0, 7'd16, 32'd0, 1'b1, 0);
    frame(1'b0, 7'd127, 32'd0, 1'b1, 0);
    frame(1'b1, 7'd2, 32'h11111111, 1'b1, 0);
    frame(1'b1, 7'd2, 32'hCAFEF00D, 1'b1, 28);
    frame(1'b1, 7'd2, 32'h22222222, 1'b1, 0);
    frame(1'b0, 7'd2, 32'd0, 1'b1, 0);
    if (PAR) begin
      frame(1'b1, 7'd3, 32'h00000001, 1'b0, 0);
      frame(1'b1, 7'd3, 32'h00000001, 1'b1, 0);
      frame(1'b1, 7'd4, 32'h12345678, 1'b1, 40);
    end

    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(DEPTH, 127))
                                         : 7'($urandom_range(0, DEPTH - 1));
      ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 39)) : 0;
      frame(wr, addr, $urandom, PAR ? 1'($urandom_range(0, 3) != 0) : 1'b1, ab);
    end
    check_all("rand_mem");

    frame(1'b1, 7'd0, 32'h0F0F0F0F, 1'b1, 0);
    d0 = done_cnt;
    e0 = err_cnt;
    xfer(8'h00, 33'd0, 14, 1'b0, mv, busy_mid);
    chk("busy_pre_rst", 64'(busy_mid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_miso", 64'(bus.miso), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_done", 64'(bus.frame_done), 64'(0));
    chk("mid_rst_err", 64'(bus.frame_err), 64'(0));
    for (int a = 0; a < DEPTH; a++) model[a] = 32'd0;
    check_all("mid_rst_mem");
    bus.ss_n = 1'b1;
    bus.sclk = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(12);
    chk("rst_no_done", 64'(done_cnt - d0), 64'(0));
    chk("rst_no_err", 64'(err_cnt - e0), 64'(0));
    frame(1'b1, 7'd5, 32'h13579BDF, 1'b1, 0);
    frame(1'b0, 7'd5, 32'd0, 1'b1, 0);
    frame(1'b0, 7'd0, 32'd0, 1'b1, 0);
    rd = model[5];
    chk("post_rst_model", 64'(bus.dbg_rdata), 64'(0));
    bus.dbg_addr = 7'd5;
    #1;
    chk("post_rst_dbg5", 64'(bus.dbg_rdata), 64'(rd));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

SPI mode-0 slave register file that sits directly downstream of the AHB-to-SPI bridge's SPI master and terminates its serial frames. It oversamples the SPI pins in the HCLK domain, decodes one command byte per frame, and performs a 32-bit write into, or read from, a small word-addressed register array. A backdoor read port and status pulses let the bench check results without going through SPI.

## Interface
- DEPTH, 16, number of 32-bit words; power of 2, 2..128
- SYNC_STAGES, 2, synchronizer flops on sclk/ss_n/mosi; minimum 2
- HCLK  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock from the bridge, idle low (mode 0)
- ss_n  in  1  active-low slave select; frame boundary
- mosi  in  1  serial data in, MSB first
- miso  out  1  serial data out, MSB first; never tristated
- busy  out  1  high while a frame is in progress (ss_n low, synchronized)
- frame_done  out  1  one-HCLK pulse on successful frame completion
- frame_err  out  1  one-HCLK pulse on a failed or aborted frame
- dbg_addr  in  7  backdoor read address
- dbg_rdata  out  32  combinational contents of mem[dbg_addr]; 0 if dbg_addr ≥ DEPTH

## Operation
- sclk, ss_n, mosi each pass through SYNC_STAGES flops; one more flop for edge detect. rise = sclk_s & ~sclk_d, fall = ~sclk_s & sclk_d.
- Frame: ss_n falls; 8-bit command (bit7 = 1 write / 0 read, bits 6:0 = address); 32 data bits; ss_n rises.
- FSM states: IDLE, CMD, DATA, WAIT_END.
  - IDLE: ss_n_s low -> CMD, bit counter = 0.
  - CMD: on each rise shift mosi into cmd register; after the 8th rise -> DATA. On a read, latch rd_word = mem[addr], or 0 if addr ≥ DEPTH.
  - DATA, write: on each rise shift mosi into data register; after the 32nd rise -> WAIT_END.
  - DATA, read: on the fall following the 8th command rise, load rd_word into the out-shifter and drive its MSB on miso. Shift on each later fall; after the 32nd rise -> WAIT_END.
  - WAIT_END: further sclk edges ignored. When ss_n_s goes high, commit and go to IDLE.
- Commit on a write: if addr < DEPTH, mem[addr] <= data and frame_done pulses. Otherwise mem is unchanged and frame_err pulses.
- Commit on a read: frame_done pulses if addr < DEPTH, otherwise frame_err pulses.
- Abort: ss_n_s high in CMD or DATA. Go to IDLE, no mem write, frame_err pulses.
- miso is 0 in IDLE, CMD and WAIT_END.
- Bit counter is 6 bits, cleared on IDLE entry; it never wraps within a frame.
- Reset mid-frame: all state to reset values immediately. The frame in flight is lost with no pulse.

## Timing
- Reset values: miso 0, busy 0, frame_done 0, frame_err 0, FSM IDLE, all counters 0, all mem words 0x00000000.
- Pin-to-event latency: SYNC_STAGES + 1 HCLK, i.e. 3 cycles at the default.
- Requirements on the SPI side:
  - sclk high and low phases each ≥ SYNC_STAGES + 2 HCLK.
  - ss_n setup to the first sclk rise ≥ SYNC_STAGES + 2 HCLK.
  - ss_n hold after the last sclk fall ≥ SYNC_STAGES + 2 HCLK.
- miso changes SYNC_STAGES + 2 HCLK after a pin-level sclk fall. It is stable at the next rise provided the sclk-phase rule above holds.
- Write commit: mem is updated and frame_done pulses SYNC_STAGES + 2 HCLK after ss_n rises.
- dbg_rdata shows the new value in the same cycle as frame_done.
- busy follows ss_n_s inverted.
- Simultaneous ss_n_s rise and a sclk edge in the same cycle: ss_n wins and the edge is ignored.

## Configuration
- SPI_SLV_PARITY_EN defined:
  - Write frames carry a 41st bit, even parity over the 32 data bits, sampled on the 33rd data-phase rise.
  - On mismatch the write is discarded and frame_err pulses.
  - Read frames are unchanged (32 bits).
  - An ss_n rise before the parity bit counts as an abort.
- SPI_SLV_PARITY_EN undefined: no parity bit; write frames are 40 bits. Extra sclk edges in WAIT_END are ignored.

## Test plan
- Write cmd 0x80, data 0xA5A5A5A5 -> frame_done once; dbg_rdata at addr 0 = 0xA5A5A5A5; miso 0 throughout.
- Then read cmd 0x01 after writing 0x5A5A5A5A to addr 1 -> 32 bits on miso = 0x5A5A5A5A; frame_done pulses.
- Write cmd 0x90 (addr 16, DEPTH 16) -> frame_err; all mem words unchanged. Read cmd 0x10 -> miso shifts 0x00000000, frame_err.
- ss_n raised after 20 data bits of a write to addr 2 holding 0x11111111 -> frame_err; mem[2] stays 0x11111111; next full frame succeeds.
- rst asserted mid-read of addr 0 -> miso, busy, frame_done and frame_err go 0 immediately; mem cleared; the next frame decodes correctly.
- With SPI_SLV_PARITY_EN, write 0x00000001 to addr 3 with parity bit 0 -> frame_err, mem[3] unchanged. With parity bit 1 -> frame_done, mem[3] = 0x00000001.
